early_detect_debouncer: RTL and testbench
=========================================

# early_detect_debouncer

Single-button debouncer using the early-detect scheme: the first observed edge on the synchronised button input is passed to the output immediately, then further input activity is ignored for a fixed hold window while contacts settle. It sits between the raw board button pin and the user logic. It drives the same counting job as the team's terminal-count timer through an internal hold counter. It supplies a clean level plus single-cycle press/release strobes.

## Interface
- `DELAY_CYCLES`, default 255: hold-window length in `clk` cycles; legal range ≥ 2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `btn_in`  input  1  raw, asynchronous button level.
- `db_out`  output  1  debounced level; reset value 0.
- `press_p`  output  1  one-cycle strobe when `db_out` goes 0→1; reset value 0.
- `release_p`  output  1  one-cycle strobe when `db_out` goes 1→0; reset value 0.

## Operation
- Two-flop synchroniser `btn_in` → `s1` → `s2`, both reset to 0; FSM uses only `s2`.
- FSM states and encoding: IDLE_LO (0), HOLD_HI (1), IDLE_HI (2), HOLD_LO (3). Reset state is IDLE_LO.
- IDLE_LO: if `s2`=1, go to HOLD_HI, set `db_out`=1, pulse `press_p`, clear the counter. Otherwise stay.
- HOLD_HI: `s2` is ignored and the counter increments. When count = `DELAY_CYCLES`-1, go to IDLE_HI.
- IDLE_HI: if `s2`=0, go to HOLD_LO, set `db_out`=0, pulse `release_p`, clear the counter. Otherwise stay.
- HOLD_LO: mirror of HOLD_HI; exits to IDLE_LO.
- Hold expiry always lands in the matching IDLE state, whatever `s2` is. A differing `s2` is acted on one cycle later, from IDLE.
- All outputs are registered; `db_out` is a direct state decode (1 in HOLD_HI and IDLE_HI).
- Counter: width `$clog2(DELAY_CYCLES)`. Cleared on HOLD entry and held at 0 in IDLE states. It never wraps, because exit happens at `DELAY_CYCLES`-1.
- Reset asserted mid-hold: next edge forces IDLE_LO, counter 0, synchroniser 0, all outputs 0. No `release_p` is generated.
- Glitches are not filtered. Any pulse long enough to be captured by `s1` produces a full press of `db_out`. This is inherent to early detect and is accepted.

## Timing
- Latency, counting the edge that first samples the new `btn_in` level as edge 1:
  - `s2` updates at edge 2.
  - `db_out` and the strobe register at edge 3.
- `press_p` and `release_p` are high for exactly one cycle, coincident with the first cycle of the new `db_out` level.
- HOLD state occupancy is exactly `DELAY_CYCLES` cycles.
- Minimum spacing between `db_out` transitions is `DELAY_CYCLES`+1 cycles.
- `press_p` and `release_p` are never both high, and never on consecutive cycles.

## Structure
- Shared package `debounce_pkg`:
  - FSM state enum/localparams (IDLE_LO, HOLD_HI, IDLE_HI, HOLD_LO).
  - Synchroniser depth constant (2).
- One sub-module, `hold_timer`:
  - Parameter `DELAY_CYCLES`.
  - Ports: `clk`, `reset`, `clr`, `en`, `done`.
  - `done` is combinational: count = `DELAY_CYCLES`-1.
  - `clr` has priority over `en`.
- The top level contains the synchroniser, the FSM and the output registers.

## Test plan
All scenarios use `DELAY_CYCLES`=8.
- Clean press: `btn_in` 0→1 and held.
  - `db_out`=1 and `press_p`=1 at edge 3.
  - `press_p` is 0 at edge 4.
  - `db_out` is still 1 at edge 100.
- Bouncy press: `btn_in` toggles every cycle for 6 cycles, then settles at 1.
  - Exactly one `press_p`.
  - `db_out` is steady 1 from edge 3 onward.
  - No `release_p`.
- Bouncy release after a stable press: `btn_in` toggles for 6 cycles, then settles at 0.
  - Exactly one `release_p`, 3 edges after the first 0.
  - `db_out` is steady 0 afterwards.
- Single-cycle glitch from idle: `btn_in`=1 for one cycle.
  - `db_out` is high for 9 cycles.
  - One `press_p`, then one `release_p`.
- Reset mid-hold: assert `reset` during HOLD_HI at count 4 while `btn_in` stays 1.
  - All outputs are 0 on the next edge.
  - After deassert, `press_p` fires 3 edges later.
- Back-to-back stable press and release: `btn_in` high for 9 cycles, then low.
  - `release_p` occurs 9 cycles after `press_p`, at the minimum spacing.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the early-detect debouncer.
//   state_t      : FSM state encoding (IDLE_LO, HOLD_HI, IDLE_HI, HOLD_LO)
//   SYNC_STAGES  : depth of the input synchroniser
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    HOLD_HI = 2'd1,
    IDLE_HI = 2'd2,
    HOLD_LO = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/hold_timer.sv
// Hold-window counter for the debouncer.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clr   in  force count to 0 (wins over en)
//   en    in  increment count
//   done  out count has reached DELAY_CYCLES-1 (combinational)
module hold_timer #(
  parameter int DELAY_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(DELAY_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == CNT_W'(DELAY_CYCLES - 1));

endmodule

// File: rtl/early_detect_debouncer.sv
// Early-detect button debouncer: the first edge seen on the synchronised
// input is passed straight through, then input activity is ignored for
// DELAY_CYCLES cycles while the contacts settle.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   btn_in    in  raw asynchronous button level
//   db_out    out debounced level
//   press_p   out one-cycle strobe on db_out 0->1
//   release_p out one-cycle strobe on db_out 1->0
module early_detect_debouncer
  import debounce_pkg::*;
#(
  parameter int DELAY_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic db_out,
  output logic press_p,
  output logic release_p
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  state_t                 state;
  state_t                 state_nxt;
  logic                   press_nxt;
  logic                   release_nxt;
  logic                   in_idle;
  logic                   in_hold;
  logic                   done;

  // Synchroniser: sync[0] is s1, sync[SYNC_STAGES-1] is s2
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign s2 = sync[SYNC_STAGES-1];

  assign in_idle = (state == IDLE_LO) || (state == IDLE_HI);
  assign in_hold = (state == HOLD_HI) || (state == HOLD_LO);

  // Clearing on done keeps the counter from stepping past DELAY_CYCLES-1
  // on the exit edge, so it is already 0 when the next hold starts.
  hold_timer #(
    .DELAY_CYCLES(DELAY_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (in_idle | done),
    .en   (in_hold),
    .done (done)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE_LO;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: s2 is ignored in HOLD; expiry always lands in IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE_LO: if (s2)   state_nxt = HOLD_HI;
      HOLD_HI: if (done) state_nxt = IDLE_HI;
      IDLE_HI: if (!s2)  state_nxt = HOLD_LO;
      HOLD_LO: if (done) state_nxt = IDLE_LO;
      default:           state_nxt = IDLE_LO;
    endcase
  end

  // Strobe decode; registered below so they align with the new db_out level
  always_comb begin
    press_nxt   = (state == IDLE_LO) && s2;
    release_nxt = (state == IDLE_HI) && !s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_p   <= 1'b0;
      release_p <= 1'b0;
    end else begin
      press_p   <= press_nxt;
      release_p <= release_nxt;
    end
  end

  assign db_out = (state == HOLD_HI) || (state == IDLE_HI);

endmodule

// File: tb/tb_early_detect_debouncer.sv
module tb_early_detect_debouncer;

  localparam int DELAY = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic db_out;
  logic press_p;
  logic release_p;

  int checks = 0;
  int failures = 0;

  early_detect_debouncer #(
    .DELAY_CYCLES(DELAY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .db_out   (db_out),
    .press_p  (press_p),
    .release_p(release_p)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling / driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_level(input logic lvl, input int n);
    btn_in = lvl;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (db_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_db db_out=%b expected=0", db_out);
    end
    checks++;
    if (press_p !== 1'b0) begin
      failures++;
      $display("FAIL reset_press press_p=%b expected=0", press_p);
    end
    checks++;
    if (release_p !== 1'b0) begin
      failures++;
      $display("FAIL reset_release release_p=%b expected=0", release_p);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({db_out, press_p, release_p} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset outs=%b expected=000", {db_out, press_p, release_p});
    end
  endtask

  // Edge e samples the btn value driven just before it
  task automatic test_clean_press();
    logic exp_db, exp_pr;
    for (int e = 1; e <= 100; e++) begin
      btn_in = 1'b1;
      tick();
      exp_db = (e >= 3);
      exp_pr = (e == 3);
      checks++;
      if (db_out !== exp_db) begin
        failures++;
        $display("FAIL clean_press_db edge=%0d db_out=%b expected=%b", e, db_out, exp_db);
      end
      checks++;
      if (press_p !== exp_pr || release_p !== 1'b0) begin
        failures++;
        $display("FAIL clean_press_strobe edge=%0d press=%b release=%b expected=%b/0",
                 e, press_p, release_p, exp_pr);
      end
    end
    drive_level(1'b0, 20);
  endtask

  task automatic test_bouncy_press();
    logic exp_db, exp_pr;
    int presses = 0, releases = 0;
    for (int e = 1; e <= 30; e++) begin
      btn_in = (e <= 6) ? logic'(e % 2) : 1'b1;
      tick();
      presses  += int'(press_p);
      releases += int'(release_p);
      exp_db = (e >= 3);
      exp_pr = (e == 3);
      checks++;
      if (db_out !== exp_db || press_p !== exp_pr) begin
        failures++;
        $display("FAIL bouncy_press edge=%0d db=%b press=%b expected=%b/%b",
                 e, db_out, press_p, exp_db, exp_pr);
      end
    end
    checks++;
    if (presses != 1 || releases != 0) begin
      failures++;
      $display("FAIL bouncy_press_count presses=%0d releases=%0d expected=1/0", presses, releases);
    end
  endtask

  // Starts from the stable pressed state left by test_bouncy_press
  task automatic test_bouncy_release();
    logic exp_db, exp_rl;
    int releases = 0, presses = 0;
    for (int e = 1; e <= 30; e++) begin
      btn_in = (e <= 6) ? logic'((e + 1) % 2 == 0 ? 1'b0 : 1'b1) : 1'b0;
      tick();
      presses  += int'(press_p);
      releases += int'(release_p);
      exp_db = (e < 3);
      exp_rl = (e == 3);
      checks++;
      if (db_out !== exp_db || release_p !== exp_rl) begin
        failures++;
        $display("FAIL bouncy_release edge=%0d db=%b release=%b expected=%b/%b",
                 e, db_out, release_p, exp_db, exp_rl);
      end
    end
    checks++;
    if (releases != 1 || presses != 0) begin
      failures++;
      $display("FAIL bouncy_release_count releases=%0d presses=%0d expected=1/0", releases, presses);
    end
  endtask

  task automatic test_glitch();
    logic exp_db, exp_pr, exp_rl;
    int high_cycles = 0;
    for (int e = 1; e <= 25; e++) begin
      btn_in = (e == 1);
      tick();
      high_cycles += int'(db_out);
      exp_db = (e >= 3 && e <= 3 + DELAY);
      exp_pr = (e == 3);
      exp_rl = (e == 4 + DELAY);
      checks++;
      if (db_out !== exp_db || press_p !== exp_pr || release_p !== exp_rl) begin
        failures++;
        $display("FAIL glitch edge=%0d db/pr/rl=%b%b%b expected=%b%b%b",
                 e, db_out, press_p, release_p, exp_db, exp_pr, exp_rl);
      end
    end
    checks++;
    if (high_cycles != DELAY + 1) begin
      failures++;
      $display("FAIL glitch_width high_cycles=%0d expected=%0d", high_cycles, DELAY + 1);
    end
  endtask

  // Reset lands at edge 8, when the hold counter has reached 4
  task automatic test_reset_mid_hold();
    logic exp_db, exp_pr;
    for (int e = 1; e <= 30; e++) begin
      btn_in = 1'b1;
      reset  = (e == 8);
      tick();
      exp_db = (e >= 3 && e < 8) || (e >= 11);
      exp_pr = (e == 3) || (e == 11);
      checks++;
      if (db_out !== exp_db || press_p !== exp_pr || release_p !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_hold edge=%0d db/pr/rl=%b%b%b expected=%b%b0",
                 e, db_out, press_p, release_p, exp_db, exp_pr);
      end
    end
    reset = 1'b0;
    drive_level(1'b0, 20);
  endtask

  task automatic test_back_to_back();
    logic exp_db, exp_pr, exp_rl;
    int press_edge = -1, release_edge = -1;
    for (int e = 1; e <= 30; e++) begin
      btn_in = (e <= 9);
      tick();
      if (press_p)   press_edge   = e;
      if (release_p) release_edge = e;
      exp_db = (e >= 3 && e <= 11);
      exp_pr = (e == 3);
      exp_rl = (e == 12);
      checks++;
      if (db_out !== exp_db || press_p !== exp_pr || release_p !== exp_rl) begin
        failures++;
        $display("FAIL back_to_back edge=%0d db/pr/rl=%b%b%b expected=%b%b%b",
                 e, db_out, press_p, release_p, exp_db, exp_pr, exp_rl);
      end
    end
    checks++;
    if (release_edge - press_edge != DELAY + 1) begin
      failures++;
      $display("FAIL back_to_back_spacing spacing=%0d expected=%0d",
               release_edge - press_edge, DELAY + 1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_bouncy_release();
    drive_level(1'b0, 20);
    test_glitch();
    test_reset_mid_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
